l1d_lc_line_bridge: RTL and testbench
=====================================

// Module: l1d_lc_line_bridge
// PURPOSE
//  Sits directly below l1_data_cache on its lower-cache (lc_*) port. Converts whole-line
//  (B-byte) fill/writeback requests into BEAT_BITS-wide memory-bus beats. For reads,
//  gathers the returned beats and hands the assembled line back to the L1D.
//  Services one request at a time. No reordering, no internal queueing.
// PARAMETERS
//  PADDR_BITS  22   physical address width
//  B           64   line size in bytes
//  BEAT_BITS   64   memory bus data width; BEATS = B*8/BEAT_BITS (8 at defaults)
// PORTS
//  clk_in         in   1          clock; all state changes on posedge
//  rst_N_in       in   1          reset, asynchronous, active-low
//  l1d_valid_in   in   1          L1D request valid (L1D lc_valid_out)
//  l1d_ready_out  out  1          bridge can accept a request (to L1D lc_ready_in)
//  l1d_addr_in    in   PADDR_BITS request address
//  l1d_value_in   in   B*8        writeback line data
//  l1d_we_in      in   1          1 = writeback, 0 = line fill
//  l1d_valid_out  out  1          fill response valid (to L1D lc_valid_in)
//  l1d_ready_in   in   1          L1D accepts response (L1D lc_ready_out)
//  l1d_addr_out   out  PADDR_BITS line-aligned response address
//  l1d_value_out  out  B*8        response line; beat i in bits [i*BEAT_BITS +: BEAT_BITS]
//  mem_valid_out  out  1          memory command valid
//  mem_ready_in   in   1          memory accepts command
//  mem_addr_out   out  PADDR_BITS command address
//  mem_we_out     out  1          1 = write beat, 0 = line read
//  mem_wdata_out  out  BEAT_BITS  write beat data
//  mem_rvalid_in  in   1          read beat valid (always accepted, in address order)
//  mem_rdata_in   in   BEAT_BITS  read beat data
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, beat count 0, line buffer 0.
//  - Transfers complete on valid&&ready at a posedge. Valid outputs held with stable data until accepted.
//  - Request address is latched line-aligned: low log2(B) bits forced to 0.
//  - States:
//    - IDLE: l1d_ready_out=1, all other valid outputs 0.
//      On l1d_valid_in, latch addr/value/we, count=0.
//      Next state is WR_BEAT if we=1, else RD_CMD.
//    - RD_CMD: mem_valid_out=1, mem_we_out=0, mem_addr_out=line addr.
//      On mem_ready_in, go to RD_DATA.
//    - RD_DATA: each mem_rvalid_in stores mem_rdata_in into slot count, then count++.
//      On the beat where count==BEATS-1, go to RESP.
//    - RESP: l1d_valid_out=1, l1d_addr_out=line addr, l1d_value_out=buffer.
//      On l1d_ready_in, go to IDLE.
//    - WR_BEAT: mem_valid_out=1, mem_we_out=1, mem_addr_out=line addr + count*(BEAT_BITS/8),
//      mem_wdata_out=slice count. On mem_ready_in, count++.
//      After the last beat, go to IDLE (see macro).
//  - l1d_ready_out=0 in every state except IDLE.
//    Minimum read occupancy: 1 + 1 + BEATS + 1 cycles.
//  - mem_rvalid_in outside RD_DATA is ignored.
//    mem_ready_in outside RD_CMD/WR_BEAT is ignored.
//  - Address arithmetic is modulo 2^PADDR_BITS. Beats never cross the line, since
//    the line address is aligned.
//  - Asynchronous reset mid-operation abandons the transfer: no partial response,
//    no further beats.
// CONFIGURATION
//  - LC_WRITE_ACK_EN defined: after the last write beat, go to WACK instead of IDLE.
//    WACK drives l1d_valid_out=1, l1d_addr_out=line addr, l1d_value_out=0.
//    On l1d_ready_in, go to IDLE.
//  - LC_WRITE_ACK_EN undefined: writebacks produce no l1d_valid_out.
// TESTING
//  1 Read 22'h060300. Beats i=0..7 return 64'h1000+i.
//    -> One mem command at 22'h060300, mem_we_out=0.
//    -> l1d_valid_out with addr 22'h060300; value word i = 64'h1000+i.
//  2 Writeback addr 22'h005000, word i = i+1.
//    -> 8 write beats at 22'h005000, 005008 ... 005038 with data 1..8.
//    -> No l1d_valid_out (macro off).
//  3 Read 22'h004050 -> mem_addr_out=22'h004040 and l1d_addr_out=22'h004040.
//  4 Backpressure: mem_ready_in low for 3 cycles at write beat 2, then l1d_ready_in
//    low for 5 cycles in RESP.
//    -> Beat 2 addr/data held stable; response held stable.
//    -> l1d_ready_out=0 throughout.
//  5 Assert rst_N_in after 3 of 8 read beats.
//    -> All outputs 0 immediately; no response.
//    -> Next read completes normally with fresh data.
//  6 With LC_WRITE_ACK_EN: case 2 -> l1d_valid_out one cycle after beat 8 is accepted,
//    addr 22'h005000, value 0.

Source files
------------

// File: rtl/l1d_lc_line_bridge.sv
// Line bridge between the L1D lower-cache port and a beat-wide memory bus.
// Splits line writebacks into beats and gathers read beats into a line fill.
// Optional feature macro: LC_WRITE_ACK_EN (acknowledge writebacks to the L1D).
module l1d_lc_line_bridge #(
  parameter int unsigned PADDR_BITS = 22,
  parameter int unsigned B          = 64,
  parameter int unsigned BEAT_BITS  = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  l1d_valid_in,
  output logic                  l1d_ready_out,
  input  logic [PADDR_BITS-1:0] l1d_addr_in,
  input  logic [B*8-1:0]        l1d_value_in,
  input  logic                  l1d_we_in,
  output logic                  l1d_valid_out,
  input  logic                  l1d_ready_in,
  output logic [PADDR_BITS-1:0] l1d_addr_out,
  output logic [B*8-1:0]        l1d_value_out,
  output logic                  mem_valid_out,
  input  logic                  mem_ready_in,
  output logic [PADDR_BITS-1:0] mem_addr_out,
  output logic                  mem_we_out,
  output logic [BEAT_BITS-1:0]  mem_wdata_out,
  input  logic                  mem_rvalid_in,
  input  logic [BEAT_BITS-1:0]  mem_rdata_in
);

  localparam int unsigned BEATS      = B * 8 / BEAT_BITS;
  localparam int unsigned BEAT_BYTES = BEAT_BITS / 8;
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [PADDR_BITS-1:0] LINE_MASK = ~PADDR_BITS'(B - 1);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle, StRdCmd, StRdData, StResp, StWrBeat, StWack
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [PADDR_BITS-1:0] addr_q;
  logic [B*8-1:0]        line_q;

  logic [CNT_W-1:0]      cnt_nxt;
  logic [PADDR_BITS-1:0] req_addr;
  logic [PADDR_BITS-1:0] next_beat_addr;
  logic [BEAT_BITS-1:0]  next_wdata;
  logic [B*8-1:0]        fill_line;

  // Derived values: aligned request address, next write beat, line with current read beat merged
  always_comb begin
    req_addr       = l1d_addr_in & LINE_MASK;
    cnt_nxt        = cnt_q + 1'b1;
    next_beat_addr = addr_q + PADDR_BITS'(cnt_nxt) * PADDR_BITS'(BEAT_BYTES);
    next_wdata     = line_q[int'(cnt_nxt) * BEAT_BITS +: BEAT_BITS];
    fill_line      = line_q;
    fill_line[int'(cnt_q) * BEAT_BITS +: BEAT_BITS] = mem_rdata_in;
  end

  // Transfer FSM; every output is a register updated on the transition that needs it
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      line_q        <= '0;
      l1d_ready_out <= 1'b0;
      l1d_valid_out <= 1'b0;
      l1d_addr_out  <= '0;
      l1d_value_out <= '0;
      mem_valid_out <= 1'b0;
      mem_addr_out  <= '0;
      mem_we_out    <= 1'b0;
      mem_wdata_out <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Ready rises one cycle after reset release, since all outputs reset to 0
          l1d_ready_out <= 1'b1;
          if (l1d_valid_in && l1d_ready_out) begin
            addr_q        <= req_addr;
            line_q        <= l1d_value_in;
            cnt_q         <= '0;
            l1d_ready_out <= 1'b0;
            mem_valid_out <= 1'b1;
            mem_addr_out  <= req_addr;
            mem_we_out    <= l1d_we_in;
            if (l1d_we_in) begin
              mem_wdata_out <= l1d_value_in[BEAT_BITS-1:0];
              state_q       <= StWrBeat;
            end else begin
              state_q <= StRdCmd;
            end
          end
        end
        StRdCmd: begin
          if (mem_ready_in) begin
            mem_valid_out <= 1'b0;
            mem_addr_out  <= '0;
            state_q       <= StRdData;
          end
        end
        StRdData: begin
          if (mem_rvalid_in) begin
            line_q <= fill_line;
            if (cnt_q == LAST_BEAT) begin
              cnt_q         <= '0;
              l1d_valid_out <= 1'b1;
              l1d_addr_out  <= addr_q;
              l1d_value_out <= fill_line;
              state_q       <= StResp;
            end else begin
              cnt_q <= cnt_nxt;
            end
          end
        end
        StResp: begin
          if (l1d_ready_in) begin
            l1d_valid_out <= 1'b0;
            l1d_addr_out  <= '0;
            l1d_value_out <= '0;
            l1d_ready_out <= 1'b1;
            state_q       <= StIdle;
          end
        end
        StWrBeat: begin
          if (mem_ready_in) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_q         <= '0;
              mem_valid_out <= 1'b0;
              mem_addr_out  <= '0;
              mem_we_out    <= 1'b0;
              mem_wdata_out <= '0;
`ifdef LC_WRITE_ACK_EN
              l1d_valid_out <= 1'b1;
              l1d_addr_out  <= addr_q;
              l1d_value_out <= '0;
              state_q       <= StWack;
`else
              l1d_ready_out <= 1'b1;
              state_q       <= StIdle;
`endif
            end else begin
              cnt_q         <= cnt_nxt;
              mem_addr_out  <= next_beat_addr;
              mem_wdata_out <= next_wdata;
            end
          end
        end
`ifdef LC_WRITE_ACK_EN
        StWack: begin
          if (l1d_ready_in) begin
            l1d_valid_out <= 1'b0;
            l1d_addr_out  <= '0;
            l1d_ready_out <= 1'b1;
            state_q       <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_l1d_lc_line_bridge.sv
// Self-checking bench for l1d_lc_line_bridge: directed vector table, backpressure,
// mid-transfer reset and randomized transactions against a line-level reference model.
module tb_l1d_lc_line_bridge;

  localparam int BEATS = 8;
`ifdef LC_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         l1d_valid_in;
  logic         l1d_ready_out;
  logic [21:0]  l1d_addr_in;
  logic [511:0] l1d_value_in;
  logic         l1d_we_in;
  logic         l1d_valid_out;
  logic         l1d_ready_in;
  logic [21:0]  l1d_addr_out;
  logic [511:0] l1d_value_out;
  logic         mem_valid_out;
  logic         mem_ready_in;
  logic [21:0]  mem_addr_out;
  logic         mem_we_out;
  logic [63:0]  mem_wdata_out;
  logic         mem_rvalid_in;
  logic [63:0]  mem_rdata_in;

  always #5 clk = ~clk;

  l1d_lc_line_bridge dut (
    .clk_in        (clk),
    .rst_N_in      (rst_n),
    .l1d_valid_in  (l1d_valid_in),
    .l1d_ready_out (l1d_ready_out),
    .l1d_addr_in   (l1d_addr_in),
    .l1d_value_in  (l1d_value_in),
    .l1d_we_in     (l1d_we_in),
    .l1d_valid_out (l1d_valid_out),
    .l1d_ready_in  (l1d_ready_in),
    .l1d_addr_out  (l1d_addr_out),
    .l1d_value_out (l1d_value_out),
    .mem_valid_out (mem_valid_out),
    .mem_ready_in  (mem_ready_in),
    .mem_addr_out  (mem_addr_out),
    .mem_we_out    (mem_we_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rvalid_in (mem_rvalid_in),
    .mem_rdata_in  (mem_rdata_in)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [21:0] addr;
    logic        we;
    int          pat;         // 0 random, 1 word i = 0x1000+i, 2 word i = i+1
    int          stall_beat;  // write beat index held off by mem_ready_in, -1 none
    int          stall_len;
    int          resp_stall;  // cycles l1d_ready_in held low while response valid
    logic [21:0] exp_la;      // expected line address on mem and response
  } vec_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input int pat);
    logic [511:0] l;
    for (int i = 0; i < BEATS; i++) begin
      case (pat)
        1:       l[i*64 +: 64] = 64'h1000 + 64'(i);
        2:       l[i*64 +: 64] = 64'(i + 1);
        default: l[i*64 +: 64] = {$urandom, $urandom};
      endcase
    end
    return l;
  endfunction

  task automatic idle_inputs();
    l1d_valid_in = 1'b0;
    l1d_addr_in  = '0;
    l1d_value_in = '0;
    l1d_we_in    = 1'b0;
    l1d_ready_in = 1'b0;
    mem_ready_in = 1'b0;
    mem_rvalid_in = 1'b0;
    mem_rdata_in = '0;
  endtask

  // One full request acting as both L1D and memory; called and returning at a negedge.
  task automatic do_txn(input logic [21:0] addr, input logic we, input logic [21:0] exp_la,
                        input logic [511:0] line, input logic [511:0] rline,
                        input int stall_beat, input int stall_len, input int resp_stall,
                        input int abort_beats);
    int beats = 0, cmds = 0, resps = 0, stall_cnt = 0, resp_wait = 0, post = 0, w = 0, cyc;
    bit cmd_done = 0, fin = 0, expect_resp_now = 0;
    bit mem_hs = 0, mv_pend = 0, rv_hs = 0, resp_hs = 0, rp_pend = 0;
    logic [21:0] p_addr = '0;
    logic [63:0] p_data = '0;
    logic        p_we = 1'b0;
    int exp_resps = we ? int'(ACK) : 1;

    while (!l1d_ready_out && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready", l1d_ready_out, 1);
    l1d_valid_in = 1'b1;
    l1d_addr_in  = addr;
    l1d_we_in    = we;
    l1d_value_in = we ? line : make_line(0);
    @(negedge clk);
    // Scramble request inputs to prove they were latched
    l1d_valid_in = 1'b0;
    l1d_addr_in  = 22'($urandom);
    l1d_value_in = ~line;
    l1d_we_in    = ~we;

    for (cyc = 0; cyc < 400; cyc++) begin
      if (mem_hs) begin
        check("mem_we", p_we, we);
        if (p_we) begin
          check("wr_addr", p_addr, exp_la + 22'(8 * beats));
          check("wr_data", p_data, line[beats*64 +: 64]);
          beats++;
          if (beats == BEATS) begin
            fin = !ACK;
            expect_resp_now = ACK;
          end
        end else begin
          check("rd_cmd_addr", p_addr, exp_la);
          cmds++;
          cmd_done = 1;
        end
      end
      if (rv_hs) begin
        beats++;
        if (beats == BEATS) expect_resp_now = 1;
      end
      if (resp_hs) begin
        resps++;
        break;
      end
      if (abort_beats > 0 && beats == abort_beats) begin
        mem_rvalid_in = 1'b0;
        return;
      end

      if (!fin) check("busy_ready", l1d_ready_out, 0);
      if (expect_resp_now) begin
        check("resp_latency", l1d_valid_out, 1);
        expect_resp_now = 0;
      end
      if (l1d_valid_out) begin
        if (beats == BEATS && (!we || ACK)) begin
          check("resp_addr", l1d_addr_out, exp_la);
          check("resp_value", l1d_value_out, we ? 512'd0 : rline);
        end else begin
          check("spurious_resp", l1d_valid_out, 0);
        end
      end else if (rp_pend) begin
        check("resp_hold", l1d_valid_out, 1);
      end
      if (mv_pend) begin
        check("mem_hold_valid", mem_valid_out, 1);
        check("mem_hold_addr", mem_addr_out, p_addr);
        check("mem_hold_data", {mem_we_out, mem_wdata_out}, {p_we, p_data});
      end
      if (mem_valid_out && (fin || (!we && cmd_done) || (we && beats == BEATS)))
        check("spurious_cmd", mem_valid_out, 0);

      // Memory side
      if (we && mem_valid_out && beats == stall_beat && stall_cnt < stall_len) begin
        mem_ready_in = 1'b0;
        stall_cnt++;
      end else begin
        mem_ready_in = ($urandom_range(0, 3) != 0);
      end
      mem_hs  = mem_valid_out && mem_ready_in;
      mv_pend = mem_valid_out && !mem_ready_in;
      p_addr  = mem_addr_out;
      p_we    = mem_we_out;
      p_data  = mem_wdata_out;
      if (!we && cmd_done && beats < BEATS) begin
        mem_rvalid_in = ($urandom_range(0, 2) != 0);
        mem_rdata_in  = rline[beats*64 +: 64];
        rv_hs = mem_rvalid_in;
      end else begin
        // Stray beats outside the data phase must be ignored
        mem_rvalid_in = ($urandom_range(0, 3) == 0);
        mem_rdata_in  = {$urandom, $urandom};
        rv_hs = 0;
      end

      // L1D response side
      if (l1d_valid_out) begin
        if (resp_wait < resp_stall) begin
          l1d_ready_in = 1'b0;
          resp_wait++;
        end else begin
          l1d_ready_in = 1'b1;
        end
      end else begin
        l1d_ready_in = 1'($urandom_range(0, 1));
      end
      resp_hs = l1d_valid_out && l1d_ready_in;
      rp_pend = l1d_valid_out && !l1d_ready_in;

      if (fin) begin
        post++;
        if (post > 4) break;
      end
      @(negedge clk);
    end

    mem_rvalid_in = 1'b0;
    mem_ready_in  = 1'b0;
    l1d_ready_in  = 1'b0;
    check("txn_timeout", cyc < 400, 1);
    check("beat_count", beats, BEATS);
    check("rd_cmd_count", cmds, we ? 0 : 1);
    check("resp_count", resps, exp_resps);
    w = 0;
    while (!l1d_ready_out && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("idle_ready", l1d_ready_out, 1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {l1d_ready_out, l1d_valid_out, l1d_addr_out, mem_valid_out, mem_addr_out,
                 mem_we_out, mem_wdata_out}, '0);
    check(name, l1d_value_out, '0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [511:0] l, r;
    logic [21:0]  a;
    logic         we;

    vecs[0] = '{22'h060300, 1'b0, 1, -1, 0, 0, 22'h060300};
    vecs[1] = '{22'h005000, 1'b1, 2, -1, 0, 0, 22'h005000};
    vecs[2] = '{22'h004050, 1'b0, 0, -1, 0, 0, 22'h004040};
    vecs[3] = '{22'h005000, 1'b1, 2,  2, 3, 0, 22'h005000};
    vecs[4] = '{22'h3fffc7, 1'b0, 0, -1, 0, 5, 22'h3fffc0};
    vecs[5] = '{22'h3ffff9, 1'b1, 0, -1, 0, 2, 22'h3fffc0};

    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      l = make_line(vecs[k].pat);
      do_txn(vecs[k].addr, vecs[k].we, vecs[k].exp_la, l, l, vecs[k].stall_beat,
             vecs[k].stall_len, vecs[k].resp_stall, 0);
    end

    // Reset after 3 of 8 read beats abandons the fill
    r = make_line(0);
    do_txn(22'h012345, 1'b0, 22'h012340, '0, r, -1, 0, 0, 3);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset_mid_outputs");
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", {l1d_valid_out, mem_valid_out}, 2'b00);
    end
    rst_n = 1'b1;
    r = make_line(0);
    do_txn(22'h012345, 1'b0, 22'h012340, '0, r, -1, 0, 0, 0);

    // Randomized traffic against the line-level model
    for (int n = 0; n < 20; n++) begin
      a  = 22'($urandom);
      we = 1'($urandom_range(0, 1));
      l  = make_line(0);
      do_txn(a, we, a & ~22'h3f, l, l, we ? int'($urandom_range(0, 7)) : -1,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
